vproc_elem_wrpack: RTL and testbench

//  Consumer end of the ELEM unit result stream. Accepts one element result per handshake
//  (32-bit value, per-byte mask, result-valid flag) and packs them, compressing out invalid

---
 rtl/vproc_pkg.sv | 22 ++
 rtl/vproc_elem_wrpack.sv | 142 ++++++++++++++
 tb/tb_vproc_elem_wrpack.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vproc_pkg.sv
// Shared vector-processor types: element-width encoding and its byte-count decode.
package vproc_pkg;

  typedef enum logic [1:0] {
    VSEW_8       = 2'b00,
    VSEW_16      = 2'b01,
    VSEW_32      = 2'b10,
    VSEW_INVALID = 2'b11
  } cfg_vsew;

  localparam int unsigned ELEM_MAX_BYTES = 4;

  // Bytes per element; the unused encoding decodes to the widest element.
  function automatic logic [2:0] vsew_bytes(input cfg_vsew vsew);
    case (vsew)
      VSEW_8:  return 3'd1;
      VSEW_16: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/vproc_elem_wrpack.sv
// Packs ELEM result beats (dropping invalid results) into full-width vector register writes.
// Input handshake: a beat transfers on in_valid_i & in_ready_o; output write on wr_valid_o & wr_ready_i.
module vproc_elem_wrpack
  import vproc_pkg::*;
#(
  parameter int unsigned VREG_W  = 128,
  parameter int unsigned VADDR_W = 5
) (
  input  logic                 clk_i,
  input  logic                 async_rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 in_res_valid_i,
  input  logic [31:0]          in_res_i,
  input  logic [3:0]           in_mask_i,
  input  logic [1:0]           in_eew_i,
  input  logic [VADDR_W-1:0]   in_vaddr_i,
  input  logic                 in_last_i,
  output logic                 wr_valid_o,
  input  logic                 wr_ready_i,
  output logic [VADDR_W-1:0]   wr_addr_o,
  output logic [VREG_W-1:0]    wr_data_o,
  output logic [VREG_W/8-1:0]  wr_be_o,
  output logic                 wr_last_o,
  output logic                 op_done_o
);

  localparam int unsigned NB = VREG_W / 8;
  localparam int unsigned PW = $clog2(NB);

  logic [PW-1:0]      ptr_q;
  logic [VADDR_W-1:0] grp_q;
  logic [VADDR_W-1:0] base_q;
  logic [1:0]         eew_q;
  logic               op_active_q;
  logic [VREG_W-1:0]  acc_data_q;
  logic [NB-1:0]      acc_be_q;

  logic               wr_valid_q;
  logic [VADDR_W-1:0] wr_addr_q;
  logic [VREG_W-1:0]  wr_data_q;
  logic [NB-1:0]      wr_be_q;
  logic               wr_last_q;
  logic               op_done_q;

  logic [2:0]         s_bytes;
  logic [PW:0]        ptr_sum;
  logic               fill;
  logic               completes;
  logic               fire;
  logic [VADDR_W-1:0] base_eff;
  logic [PW-1:0]      lane;
  logic [VREG_W-1:0]  acc_data_n;
  logic [NB-1:0]      acc_be_n;

  assign s_bytes  = vsew_bytes(cfg_vsew'(in_eew_i));
  assign ptr_sum  = {1'b0, ptr_q} + (PW+1)'(s_bytes);
  assign fill     = in_res_valid_i && (ptr_sum == (PW+1)'(NB));
  // Pointer is non-zero exactly when the accumulator holds packed bytes.
  assign completes = fill | (in_last_i & ((ptr_q != '0) | in_res_valid_i));
  assign in_ready_o = ~completes | ~wr_valid_q | wr_ready_i;
  assign fire       = in_valid_i & in_ready_o;
  assign base_eff   = op_active_q ? base_q : in_vaddr_i;

  always_comb begin
    acc_data_n = acc_data_q;
    acc_be_n   = acc_be_q;
    lane       = '0;
    if (in_res_valid_i) begin
      for (int i = 0; i < ELEM_MAX_BYTES; i++) begin
        if (3'(i) < s_bytes) begin
          lane = ptr_q + PW'(i);
          acc_data_n[lane*8 +: 8] = in_mask_i[i] ? in_res_i[i*8 +: 8] : 8'h00;
          acc_be_n[lane]          = in_mask_i[i];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      ptr_q       <= '0;
      grp_q       <= '0;
      base_q      <= '0;
      eew_q       <= '0;
      op_active_q <= 1'b0;
      acc_data_q  <= '0;
      acc_be_q    <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_be_q     <= '0;
      wr_last_q   <= 1'b0;
      op_done_q   <= 1'b0;
    end else begin
      op_done_q <= fire & in_last_i;
      if (wr_valid_q & wr_ready_i) begin
        wr_valid_q <= 1'b0;
      end
      if (fire) begin
        if (!op_active_q) begin
          base_q <= in_vaddr_i;
          eew_q  <= in_eew_i;
        end
        op_active_q <= ~in_last_i;
        if (completes) begin
          wr_valid_q <= 1'b1;
          wr_addr_q  <= base_eff + grp_q;
          wr_data_q  <= acc_data_n;
          wr_be_q    <= acc_be_n;
          wr_last_q  <= in_last_i;
          acc_data_q <= '0;
          acc_be_q   <= '0;
          ptr_q      <= '0;
          grp_q      <= grp_q + 1'b1;
        end else begin
          acc_data_q <= acc_data_n;
          acc_be_q   <= acc_be_n;
          if (in_res_valid_i) begin
            ptr_q <= ptr_sum[PW-1:0];
          end
        end
        if (in_last_i) begin
          ptr_q <= '0;
          grp_q <= '0;
        end
      end
    end
  end

  // Element width must stay constant for the whole operation.
  eew_stable_a: assert property (@(posedge clk_i) disable iff (async_rst_i)
    (fire && op_active_q) |-> (in_eew_i == eew_q));

  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign wr_be_o    = wr_be_q;
  assign wr_last_o  = wr_last_q;
  assign op_done_o  = op_done_q;

endmodule

// File: tb/tb_vproc_elem_wrpack.sv
// Directed bench for vproc_elem_wrpack: packing per element width, compression, stalls, reset.
module tb_vproc_elem_wrpack;

  localparam int unsigned VREG_W  = 128;
  localparam int unsigned VADDR_W = 5;
  localparam int unsigned NB      = VREG_W / 8;
  localparam int unsigned WR_W    = VADDR_W + VREG_W + NB + 1;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic               in_res_valid = 1'b0;
  logic [31:0]        in_res = '0;
  logic [3:0]         in_mask = '0;
  logic [1:0]         in_eew = '0;
  logic [VADDR_W-1:0] in_vaddr = '0;
  logic               in_last = 1'b0;
  logic               wr_valid;
  logic               wr_ready = 1'b1;
  logic [VADDR_W-1:0] wr_addr;
  logic [VREG_W-1:0]  wr_data;
  logic [NB-1:0]      wr_be;
  logic               wr_last;
  logic               op_done;

  int tests_run = 0;
  int tests_failed = 0;

  logic [WR_W-1:0] exp_q[$];
  logic [WR_W-1:0] got_q[$];

  vproc_elem_wrpack #(.VREG_W(VREG_W), .VADDR_W(VADDR_W)) dut (
    .clk_i(clk), .async_rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_res_valid_i(in_res_valid),
    .in_res_i(in_res), .in_mask_i(in_mask), .in_eew_i(in_eew), .in_vaddr_i(in_vaddr),
    .in_last_i(in_last),
    .wr_valid_o(wr_valid), .wr_ready_i(wr_ready), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .wr_be_o(wr_be), .wr_last_o(wr_last), .op_done_o(op_done)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Write monitor: records every transferred register write.
  always @(negedge clk) begin
    if (!rst && wr_valid && wr_ready) got_q.push_back({wr_addr, wr_data, wr_be, wr_last});
  end

  // Driver: called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic drive_beat(input logic rv, input logic [31:0] res, input logic [3:0] mask,
                            input logic [1:0] eew, input logic [VADDR_W-1:0] vaddr,
                            input logic last);
    int waited;
    in_valid = 1'b1; in_res_valid = rv; in_res = res; in_mask = mask;
    in_eew = eew; in_vaddr = vaddr; in_last = last;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      tests_run++; tests_failed++;
      $display("FAIL beat_accept: in_ready=%0b after %0d cycles, required 1", in_ready, waited);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_writes(input int n);
    int c;
    c = 0;
    while (got_q.size() < n && c < 30) begin
      @(negedge clk);
      c++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #2;
    tests_run++;
    if ({wr_valid, wr_addr, wr_data, wr_be, wr_last, op_done} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got v=%0b a=%0h d=%h be=%h l=%0b done=%0b, required all 0",
               wr_valid, wr_addr, wr_data, wr_be, wr_last, op_done);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_eew32_full;
    logic [31:0] v;
    logic [WR_W-1:0] e, g;
    @(posedge clk); #1;
    for (int k = 1; k <= 4; k++) begin
      v = 32'h11111111 * k;
      drive_beat(1'b1, v, 4'hF, 2'b10, 5'd8, k == 4);
    end
    @(negedge clk);
    tests_run++;
    if (op_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL eew32_op_done: got %0b, required 1", op_done);
    end
    tests_run++;
    if (wr_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL eew32_wr_latency: wr_valid got %0b, required 1", wr_valid);
    end
    @(negedge clk);
    tests_run++;
    if (op_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL eew32_op_done_pulse: got %0b, required 0", op_done);
    end
    exp_q.push_back({5'd8, 128'h44444444_33333333_22222222_11111111, 16'hFFFF, 1'b1});
    wait_writes(1);
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL eew32_write_count: got %0d, required %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests_run++;
      if (g !== e) begin
        tests_failed++;
        $display("FAIL eew32_write: got %h, required %h", g, e);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_eew8_two_regs;
    logic [VREG_W-1:0] d1;
    logic [WR_W-1:0] e, g;
    @(posedge clk); #1;
    for (int k = 0; k < 20; k++) drive_beat(1'b1, 32'(k), 4'h1, 2'b00, 5'd3, k == 19);
    @(negedge clk);
    tests_run++;
    if (op_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL eew8_op_done: got %0b, required 1", op_done);
    end
    for (int b = 0; b < 16; b++) d1[b*8 +: 8] = 8'(b);
    exp_q.push_back({5'd3, d1, 16'hFFFF, 1'b0});
    exp_q.push_back({5'd4, {96'h0, 32'h13121110}, 16'h000F, 1'b1});
    wait_writes(2);
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL eew8_write_count: got %0d, required %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests_run++;
      if (g !== e) begin
        tests_failed++;
        $display("FAIL eew8_write: got %h, required %h", g, e);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_eew16_compress;
    logic [31:0] vals [4];
    logic [3:0]  rvs;
    logic [WR_W-1:0] e, g;
    vals[0] = 32'h0000AAAA; vals[1] = 32'h0000BBBB; vals[2] = 32'h0000CCCC; vals[3] = 32'h0000DDDD;
    rvs = 4'b1101;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) drive_beat(rvs[k], vals[k], 4'h3, 2'b01, 5'd5, k == 3);
    exp_q.push_back({5'd5, {80'h0, 48'hDDDD_CCCC_AAAA}, 16'h003F, 1'b1});
    wait_writes(1);
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL eew16_write_count: got %0d, required %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests_run++;
      if (g !== e) begin
        tests_failed++;
        $display("FAIL eew16_compress_write: got %h, required %h", g, e);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_backpressure;
    logic [VREG_W-1:0] d1, d2;
    logic [WR_W-1:0] e, g;
    logic hold_bad;
    d1 = {32'hA0000004, 32'hA0000003, 32'hA0000002, 32'hA0000001};
    d2 = {32'hA0000008, 32'hA0000007, 32'hA0000006, 32'hA0000005};
    @(posedge clk); #1;
    wr_ready = 1'b0;
    for (int k = 1; k <= 7; k++) drive_beat(1'b1, 32'hA0000000 + 32'(k), 4'hF, 2'b10, 5'd12, 1'b0);
    in_valid = 1'b1; in_res_valid = 1'b1; in_res = 32'hA0000008; in_mask = 4'hF;
    in_eew = 2'b10; in_vaddr = 5'd12; in_last = 1'b1;
    hold_bad = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (in_ready !== 1'b0) hold_bad = 1'b1;
    end
    tests_run++;
    if (hold_bad) begin
      tests_failed++;
      $display("FAIL bp_in_ready_hold: in_ready went %0b during stall, required 0", in_ready);
    end
    tests_run++;
    if ({wr_valid, wr_addr, wr_data} !== {1'b1, 5'd12, d1}) begin
      tests_failed++;
      $display("FAIL bp_output_hold: got v=%0b a=%0d d=%h, required v=1 a=12 d=%h",
               wr_valid, wr_addr, wr_data, d1);
    end
    @(posedge clk); #1;
    wr_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_in_ready_release: got %0b, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    tests_run++;
    if (op_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_op_done: got %0b, required 1", op_done);
    end
    exp_q.push_back({5'd12, d1, 16'hFFFF, 1'b0});
    exp_q.push_back({5'd13, d2, 16'hFFFF, 1'b1});
    wait_writes(2);
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL bp_write_count: got %0d, required %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests_run++;
      if (g !== e) begin
        tests_failed++;
        $display("FAIL bp_write: got %h, required %h", g, e);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_empty_last_wrap;
    logic [VREG_W-1:0] d1, d2;
    logic [WR_W-1:0] e, g;
    d1 = {32'hB0000004, 32'hB0000003, 32'hB0000002, 32'hB0000001};
    d2 = {32'hB0000008, 32'hB0000007, 32'hB0000006, 32'hB0000005};
    @(posedge clk); #1;
    for (int k = 1; k <= 8; k++) drive_beat(1'b1, 32'hB0000000 + 32'(k), 4'hF, 2'b10, 5'd31, 1'b0);
    drive_beat(1'b0, 32'hDEADBEEF, 4'hF, 2'b10, 5'd31, 1'b1);
    @(negedge clk);
    tests_run++;
    if (op_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL empty_last_op_done: got %0b, required 1", op_done);
    end
    exp_q.push_back({5'd31, d1, 16'hFFFF, 1'b0});
    exp_q.push_back({5'd0, d2, 16'hFFFF, 1'b0});
    wait_writes(3);
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL empty_last_write_count: got %0d, required %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests_run++;
      if (g !== e) begin
        tests_failed++;
        $display("FAIL empty_last_write: got %h, required %h", g, e);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_midop;
    logic [WR_W-1:0] e, g;
    @(posedge clk); #1;
    wr_ready = 1'b0;
    for (int k = 1; k <= 6; k++) drive_beat(1'b1, 32'hC0000000 + 32'(k), 4'hF, 2'b10, 5'd10, 1'b0);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({wr_valid, wr_addr, wr_data, wr_be, wr_last, op_done} !== '0) begin
      tests_failed++;
      $display("FAIL midop_reset_outputs: got v=%0b a=%0h d=%h be=%h l=%0b done=%0b, required all 0",
               wr_valid, wr_addr, wr_data, wr_be, wr_last, op_done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    wr_ready = 1'b1;
    got_q.delete();
    drive_beat(1'b1, 32'hD0000001, 4'hF, 2'b10, 5'd20, 1'b0);
    drive_beat(1'b1, 32'hD0000002, 4'hF, 2'b10, 5'd20, 1'b1);
    exp_q.push_back({5'd20, {64'h0, 32'hD0000002, 32'hD0000001}, 16'h00FF, 1'b1});
    wait_writes(1);
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL midop_write_count: got %0d, required %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests_run++;
      if (g !== e) begin
        tests_failed++;
        $display("FAIL midop_after_reset_write: got %h, required %h", g, e);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    test_reset();
    test_eew32_full();
    test_eew8_two_regs();
    test_eew16_compress();
    test_backpressure();
    test_empty_last_wrap();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
